// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store memory access controller.
// Contents: FSM state type, RV32I load/store funct3 encodings, and a
// helper that says whether a funct3 is legal for a load or for a store.
package mem_access_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_legal_funct3(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane alignment for byte/half/word accesses on a 32-bit word.
// Ports:
//   word        in  32  word read from memory
//   addr        in  2   byte offset within the word
//   funct3      in  3   RV32I size/sign encoding
//   wdata       in  32  store data, right-aligned
//   load_data   out 32  selected lane, sign/zero extended (word passes through)
//   merged_word out 32  word with the store lane replaced by wdata
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{addr, 3'b000} +: 8];
    half_lane = word[{addr[1], 4'b0000} +: 16];

    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_data = {24'b0, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_data = {16'b0, half_lane};
      default: load_data = word;
    endcase

    merged_word = word;
    case (funct3)
      F3_B:    merged_word[{addr, 3'b000} +: 8]    = wdata[7:0];
      F3_H:    merged_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a single-port synchronous word memory.
// Byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests become word accesses;
// sub-word stores are done as read-modify-write.
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   req_valid/req_ready  request handshake; ready only while idle
//   req_we/req_funct3    store flag and RV32I size/sign encoding
//   req_addr/req_wdata   byte address and right-aligned store data
//   rsp_valid            one-cycle response pulse
//   rsp_err/rsp_rdata    error flag and load result, zero outside the pulse
//   memRead/memWrite     one-cycle memory strobes, never together
//   address/dataIn       word address and write data to memory
//   dataOut              memory read data, valid the cycle after memRead
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [31:0]           dataIn,
  input  logic [31:0]           dataOut
);

  if (WORD_WIDTH != 32) begin : g_width_check
    $error("mem_access_ctrl supports WORD_WIDTH == 32 only");
  end

  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        bad_req;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign req_ready = (state == IDLE);

  always_comb begin
    bad_req = !is_legal_funct3(req_we, req_funct3) ||
              (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
              ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00)) ||
              ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  end

  mem_lane_align u_align (
    .word        (dataOut),
    .addr        (off_q),
    .funct3      (f3_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Strobes and response fields default low each cycle, so each is only
  // high in the single state entered by the transition that sets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      address   <= '0;
      dataIn    <= '0;
    end else begin
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            address <= req_addr[ADDR_WIDTH+1:2];
            if (bad_req) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (req_we && (req_funct3 == F3_W)) begin
              state    <= WRITE;
              memWrite <= 1'b1;
              dataIn   <= req_wdata;
            end else begin
              state   <= READ;
              memRead <= 1'b1;
            end
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          if (we_q) begin
            state    <= WRITE;
            memWrite <= 1'b1;
            dataIn   <= merged_word;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
          end
        end
        WRITE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  a_no_rd_wr : assert property (@(posedge clk) !(memRead && memWrite))
    else $error("memRead and memWrite asserted together");

endmodule
